// File: rtl/reg_file_sb.sv
// General register file with NUM_RD combinational read ports, one write port,
// optional write-to-read bypass, hardwired-zero r0 and a per-register busy scoreboard.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wa,
  input  logic [DATA_W-1:0]        wd,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_a,
  output logic                     rsv_waw
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [1:NREGS-1];
  logic [NREGS-1:1]  busy_q;
  logic [NREGS-1:0]  busy;

  logic wr_ok;
  logic rsv_ok;

  assign wr_ok  = we & (wa != '0);
  assign rsv_ok = rsv_en & (rsv_a != '0);
  assign busy   = {busy_q, 1'b0};

  // Reservation is applied after the write-clear so a younger producer keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs   <= '{default: '0};
      busy_q <= '0;
    end else begin
      if (wr_ok) begin
        regs[wa]   <= wd;
        busy_q[wa] <= 1'b0;
      end
      if (rsv_ok) begin
        busy_q[rsv_a] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] a;
      a = ra[i*ADDR_W +: ADDR_W];
      if (a == '0) begin
        rd[i*DATA_W +: DATA_W] = '0;
        rd_busy[i]             = 1'b0;
      end else if ((BYPASS != 0) && we && (wa == a)) begin
        rd[i*DATA_W +: DATA_W] = wd;
        rd_busy[i]             = 1'b0;
      end else begin
        rd[i*DATA_W +: DATA_W] = regs[a];
        rd_busy[i]             = busy[a];
      end
    end
  end

  assign rsv_waw = rsv_ok & busy[rsv_a] & ~(we & (wa == rsv_a));

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed self-checking bench for reg_file_sb; runs a bypassing and a
// non-bypassing instance side by side on shared stimulus.
module tb_reg_file_sb;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [9:0]  ra;
  logic        rsv_en;
  logic [4:0]  rsv_a;

  logic [63:0] rd_b, rd_n;
  logic [1:0]  bz_b, bz_n;
  logic        waw_b, waw_n;

  int checks = 0;
  int errors = 0;

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rd(rd_b), .rd_busy(bz_b), .rsv_en(rsv_en), .rsv_a(rsv_a), .rsv_waw(waw_b)
  );

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0)) u_nob (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .ra(ra),
    .rd(rd_n), .rd_busy(bz_n), .rsv_en(rsv_en), .rsv_a(rsv_a), .rsv_waw(waw_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; rsv_en = 1'b0; rsv_a = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    ra = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Reset state on every address, both ports, both instances
    for (int a = 0; a < 32; a++) begin
      ra = {a[4:0], a[4:0]};
      #1;
      chk("reset_rd_byp", rd_b, 64'h0);
      chk("reset_rd_nob", rd_n, 64'h0);
      chk("reset_busy_byp", {62'h0, bz_b}, 64'h0);
      chk("reset_busy_nob", {62'h0, bz_n}, 64'h0);
    end

    // Write r5 with same-cycle read
    ra = {5'd0, 5'd5};
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    #1;
    chk("byp_same_cycle_r5", rd_b[31:0], 32'hDEADBEEF);
    chk("byp_same_cycle_busy", {62'h0, bz_b}, 64'h0);
    chk("nob_same_cycle_r5", rd_n[31:0], 32'h0);
    tick();
    idle();
    #1;
    chk("byp_after_edge_r5", rd_b[31:0], 32'hDEADBEEF);
    chk("nob_after_edge_r5", rd_n[31:0], 32'hDEADBEEF);

    // Write to r0 is discarded
    ra = {5'd0, 5'd0};
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF;
    #1;
    chk("r0_write_same_byp", rd_b, 64'h0);
    chk("r0_write_same_nob", rd_n, 64'h0);
    tick();
    idle();
    #1;
    chk("r0_write_next_byp", rd_b, 64'h0);
    chk("r0_write_next_nob", rd_n, 64'h0);
    rsv_en = 1'b1; rsv_a = 5'd0;
    #1;
    chk("r0_rsv_waw", {63'h0, waw_b}, 64'h0);
    tick();
    idle();
    #1;
    chk("r0_rsv_busy", {62'h0, bz_b}, 64'h0);

    // Reserve r7, observe busy, then write with bypass
    ra = {5'd7, 5'd0};
    rsv_en = 1'b1; rsv_a = 5'd7;
    #1;
    chk("rsv7_same_cycle_busy", {63'h0, bz_b[1]}, 64'h0);
    tick();
    idle();
    #1;
    chk("rsv7_busy_byp", {63'h0, bz_b[1]}, 64'h1);
    chk("rsv7_busy_nob", {63'h0, bz_n[1]}, 64'h1);
    we = 1'b1; wa = 5'd7; wd = 32'h12345678;
    #1;
    chk("wr7_byp_busy", {63'h0, bz_b[1]}, 64'h0);
    chk("wr7_byp_rd", rd_b[63:32], 32'h12345678);
    chk("wr7_nob_busy", {63'h0, bz_n[1]}, 64'h1);
    chk("wr7_nob_rd", rd_n[63:32], 32'h0);
    tick();
    idle();
    #1;
    chk("wr7_next_busy_byp", {63'h0, bz_b[1]}, 64'h0);
    chk("wr7_next_busy_nob", {63'h0, bz_n[1]}, 64'h0);
    chk("wr7_next_rd_nob", rd_n[63:32], 32'h12345678);

    // Same edge write and reserve of r9: reserve wins
    ra = {5'd0, 5'd9};
    we = 1'b1; wa = 5'd9; wd = 32'hA5A5A5A5;
    rsv_en = 1'b1; rsv_a = 5'd9;
    #1;
    chk("r9_same_waw", {63'h0, waw_b}, 64'h0);
    chk("r9_same_rd_byp", rd_b[31:0], 32'hA5A5A5A5);
    tick();
    idle();
    #1;
    chk("r9_after_rd_byp", rd_b[31:0], 32'hA5A5A5A5);
    chk("r9_after_rd_nob", rd_n[31:0], 32'hA5A5A5A5);
    chk("r9_after_busy_byp", {63'h0, bz_b[0]}, 64'h1);
    chk("r9_after_busy_nob", {63'h0, bz_n[0]}, 64'h1);

    // Double reservation of r3
    rsv_en = 1'b1; rsv_a = 5'd3;
    #1;
    chk("r3_first_waw", {63'h0, waw_b}, 64'h0);
    tick();
    #1;
    chk("r3_second_waw_byp", {63'h0, waw_b}, 64'h1);
    chk("r3_second_waw_nob", {63'h0, waw_n}, 64'h1);
    we = 1'b1; wa = 5'd3; wd = 32'h00000033;
    #1;
    chk("r3_waw_masked_by_write", {63'h0, waw_b}, 64'h0);
    tick();
    idle();

    // Mid-run asynchronous reset
    ra = {5'd7, 5'd9};
    #1;
    chk("pre_reset_rd", rd_b, {32'h12345678, 32'hA5A5A5A5});
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_rd_byp", rd_b, 64'h0);
    chk("async_reset_rd_nob", rd_n, 64'h0);
    chk("async_reset_busy", {62'h0, bz_b}, 64'h0);
    rsv_en = 1'b1; rsv_a = 5'd9;
    #1;
    chk("async_reset_waw", {63'h0, waw_b}, 64'h0);
    rsv_en = 1'b0;
    ra = {5'd0, 5'd5};
    we = 1'b1; wa = 5'd5; wd = 32'h11111111;
    tick();
    we = 1'b0;
    #1;
    chk("reset_blocks_write_nob", rd_n[31:0], 32'h0);
    reset = 1'b0;
    idle();
    #1;
    chk("post_reset_r5_byp", rd_b[31:0], 32'h0);
    chk("post_reset_r5_nob", rd_n[31:0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
